// File: rtl/job_abort_sequencer_if.sv
// job_abort_sequencer_if: requester <-> sequencer bundle (start/abort/payload in, status/result out).
// Latency: pure wiring, no storage.
// Backpressure: none; the requester sees busy/done/aborted and the sequencer ignores out-of-state requests.
interface job_abort_sequencer_if #(
  parameter int CNT_W  = 4,
  parameter int DATA_W = 4
);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  run_cnt;

  // Requester side: issues jobs, observes status and result.
  modport master (
    output start, abort, data_in,
    input  busy, done, aborted, result, run_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, abort, data_in,
    output busy, done, aborted, result, run_cnt
  );
endinterface

// File: rtl/job_abort_sequencer.sv
// job_abort_sequencer: runs one timed job (accept -> RUN_CYCLES in RUN -> commit payload to result), killable before commit.
// Latency: RUN_CYCLES cycles in RUN, one DONE or ABORT pulse cycle, then IDLE; next job earliest one cycle later.
// Backpressure: none; start is honoured only in IDLE, abort only in RUN. Watchdog kill path built when JOB_ABORT_SEQUENCER_WDOG_EN is defined.
module job_abort_sequencer #(
  parameter int CNT_W       = 4,
  parameter int RUN_CYCLES  = 4,
  parameter int WDOG_PERIOD = 3,
  parameter int DATA_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  job_abort_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_run_cnt, w_run_cnt_nxt;
  logic [DATA_W-1:0] r_payload, w_payload_nxt;
  logic [DATA_W-1:0] r_result, w_result_nxt;
  logic              w_wdog_hit;

`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
  logic [CNT_W-1:0]  r_wd, w_wd_nxt;

  // Watchdog expires on the edge that closes the WDOG_PERIOD-th RUN cycle.
  assign w_wdog_hit = (r_wd == CNT_W'(WDOG_PERIOD - 1));
`else
  logic [CNT_W-1:0]  w_unused_wdog;

  // Without the watchdog only the abort input can kill a job.
  assign w_wdog_hit    = 1'b0;
  assign w_unused_wdog = CNT_W'(WDOG_PERIOD - 1);
`endif

  // Next-state, counter and latch updates; abort beats watchdog beats commit.
  always_comb begin
    w_state_nxt   = r_state;
    w_run_cnt_nxt = r_run_cnt;
    w_payload_nxt = r_payload;
    w_result_nxt  = r_result;
`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
    w_wd_nxt      = r_wd;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = S_RUN;
          w_run_cnt_nxt = CNT_W'(RUN_CYCLES - 1);
          w_payload_nxt = bus.data_in;
`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
          w_wd_nxt      = '0;
`endif
        end
      end
      S_RUN: begin
        if (bus.abort || w_wdog_hit) begin
          w_state_nxt = S_ABORT;
        end else if (r_run_cnt == '0) begin
          w_state_nxt  = S_DONE;
          w_result_nxt = r_payload;
        end else begin
          w_run_cnt_nxt = r_run_cnt - 1'b1;
`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
          w_wd_nxt      = r_wd + 1'b1;
`endif
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight job without a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_run_cnt <= '0;
      r_payload <= '0;
      r_result  <= '0;
`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
      r_wd      <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_cnt_nxt;
      r_payload <= w_payload_nxt;
      r_result  <= w_result_nxt;
`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
      r_wd      <= w_wd_nxt;
`endif
    end
  end

  // Status decoded purely from state so done/aborted/busy are mutually exclusive.
  assign bus.busy    = (r_state == S_RUN);
  assign bus.done    = (r_state == S_DONE);
  assign bus.aborted = (r_state == S_ABORT);
  assign bus.result  = r_result;
  assign bus.run_cnt = r_run_cnt;

endmodule

// File: tb/tb_job_abort_sequencer.sv
// tb_job_abort_sequencer: directed vector table plus hand sequences for reset and watchdog corners.
// Latency: inputs applied after a rising edge, outputs compared 1 time unit after the next rising edge.
// Backpressure: n/a.
module tb_job_abort_sequencer;

  logic       clk;
  logic       rst;
  logic       tb_start;
  logic       tb_abort;
  logic [3:0] tb_data;

  int n_checks;
  int n_fail;

  job_abort_sequencer_if #(.CNT_W(4), .DATA_W(4)) bus ();
  assign bus.start   = tb_start;
  assign bus.abort   = tb_abort;
  assign bus.data_in = tb_data;

  job_abort_sequencer #(
    .CNT_W(4), .RUN_CYCLES(4), .WDOG_PERIOD(5), .DATA_W(4)
  ) u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
  job_abort_sequencer_if #(.CNT_W(4), .DATA_W(4)) bus_wd ();
  job_abort_sequencer_if #(.CNT_W(4), .DATA_W(4)) bus_tie ();
  assign bus_wd.start    = tb_start;
  assign bus_wd.abort    = tb_abort;
  assign bus_wd.data_in  = tb_data;
  assign bus_tie.start   = tb_start;
  assign bus_tie.abort   = tb_abort;
  assign bus_tie.data_in = tb_data;

  job_abort_sequencer #(
    .CNT_W(4), .RUN_CYCLES(4), .WDOG_PERIOD(3), .DATA_W(4)
  ) u_wd (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_wd)
  );

  job_abort_sequencer #(
    .CNT_W(4), .RUN_CYCLES(4), .WDOG_PERIOD(4), .DATA_W(4)
  ) u_tie (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_tie)
  );
`endif

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] data;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] result;
    logic [3:0] cnt;
  } vec_t;

  vec_t vt [20];

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic [3:0] d);
    tb_start = s;
    tb_abort = a;
    tb_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic dn,
                         input logic ab, input logic [3:0] r, input logic [3:0] c);
    chk({tag, ".busy"},    int'(bus.busy),    int'(b));
    chk({tag, ".done"},    int'(bus.done),    int'(dn));
    chk({tag, ".aborted"}, int'(bus.aborted), int'(ab));
    chk({tag, ".result"},  int'(bus.result),  int'(r));
    chk({tag, ".run_cnt"}, int'(bus.run_cnt), int'(c));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            start abort data   busy done abrt result cnt
    vt[0]  = '{1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 4'd3};
    vt[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'd2};
    vt[2]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'd1};
    vt[3]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0};
    vt[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 4'd0};
    vt[5]  = '{1'b1, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h1, 4'd0};
    vt[6]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 4'd0};
    vt[7]  = '{1'b1, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 4'h1, 4'd3};
    vt[8]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1, 4'd2};
    vt[9]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 4'd2};
    vt[10] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h1, 4'd2};
    vt[11] = '{1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 4'h1, 4'd3};
    vt[12] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h1, 4'd2};
    vt[13] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h1, 4'd1};
    vt[14] = '{1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h1, 4'd0};
    vt[15] = '{1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 4'h5, 4'd0};
    vt[16] = '{1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 4'h5, 4'd0};
    vt[17] = '{1'b1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, 4'h5, 4'd3};
    vt[18] = '{1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5, 4'd3};
    vt[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd3};

    // Reset held with start asserted: nothing may leave IDLE.
    rst      = 1'b1;
    tb_start = 1'b1;
    tb_abort = 1'b0;
    tb_data  = 4'h1;
    #1;
    chk_all("reset_t0", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h1);
      chk_all("reset_hold", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0);
    end
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      step(vt[i].start, vt[i].abort, vt[i].data);
      chk_all($sformatf("vec%0d", i), vt[i].busy, vt[i].done, vt[i].aborted,
              vt[i].result, vt[i].cnt);
    end

    // Reset asserted in the 2nd RUN cycle: busy drops at once, result cleared, no pulses.
    step(1'b1, 1'b0, 4'hA);
    chk_all("midrun_c1", 1'b1, 1'b0, 1'b0, 4'h5, 4'd3);
    step(1'b0, 1'b0, 4'h0);
    chk_all("midrun_c2", 1'b1, 1'b0, 1'b0, 4'h5, 4'd2);
    #1 rst = 1'b1;
    #1;
    chk_all("midrun_async", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'h0);
      chk_all("midrun_held", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0);
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 4'h0);
    chk_all("midrun_idle", 1'b0, 1'b0, 1'b0, 4'h0, 4'd0);

`ifdef JOB_ABORT_SEQUENCER_WDOG_EN
    // One job seen by three watchdog periods: 3 kills after 3 RUN cycles,
    // 4 ties with the run count and still kills, 5 lets the job commit.
    begin
      logic [4:0] wd_busy, wd_abt, tie_busy, tie_abt, dut_busy, dut_done;
      wd_busy  = 5'b00111;
      wd_abt   = 5'b01000;
      tie_busy = 5'b01111;
      tie_abt  = 5'b10000;
      dut_busy = 5'b01111;
      dut_done = 5'b10000;
      for (int i = 0; i < 5; i++) begin
        step((i == 0), 1'b0, 4'h1);
        chk($sformatf("wd3_busy%0d", i),  int'(bus_wd.busy),     int'(wd_busy[i]));
        chk($sformatf("wd3_abt%0d", i),   int'(bus_wd.aborted),  int'(wd_abt[i]));
        chk($sformatf("wd3_done%0d", i),  int'(bus_wd.done),     0);
        chk($sformatf("wd3_res%0d", i),   int'(bus_wd.result),   0);
        chk($sformatf("tie_busy%0d", i),  int'(bus_tie.busy),    int'(tie_busy[i]));
        chk($sformatf("tie_abt%0d", i),   int'(bus_tie.aborted), int'(tie_abt[i]));
        chk($sformatf("tie_done%0d", i),  int'(bus_tie.done),    0);
        chk($sformatf("tie_res%0d", i),   int'(bus_tie.result),  0);
        chk($sformatf("wd5_busy%0d", i),  int'(bus.busy),        int'(dut_busy[i]));
        chk($sformatf("wd5_done%0d", i),  int'(bus.done),        int'(dut_done[i]));
        chk($sformatf("wd5_abt%0d", i),   int'(bus.aborted),     0);
        chk($sformatf("wd5_res%0d", i),   int'(bus.result),      (i == 4) ? 1 : 0);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
